earom_upload: RTL and testbench
===============================

// Module: earom_upload
// PURPOSE
//  Transmit side of the HPS ioctl upload path: streams the high-score EAROM image (64x8) back to the HPS
//  byte-by-byte on ioctl_rd requests, the reverse of the ROM download stream. Sits in the emu top between
//  hps_io and the EAROM's second read port; yields to CPU EAROM accesses and paces HPS with ioctl_wait.
// PARAMETERS
//  ADDR_W   6    EAROM address width
//  DEPTH    64   number of valid EAROM bytes (<= 2**ADDR_W)
//  MEM_LAT  1    EAROM read latency in clk_sys cycles (1..3)
// PORTS
//  clk_sys        in   1   system clock (hps_io domain)
//  reset          in   1   asynchronous, active-high reset
//  ioctl_upload   in   1   HPS upload session active (level)
//  ioctl_rd       in   1   one-cycle byte request
//  ioctl_addr     in   25  requested byte address
//  ioctl_din      out  8   returned byte
//  ioctl_wait     out  1   high while a request is outstanding
//  cpu_busy       in   1   CPU owns EAROM this cycle; upload must not issue
//  mem_rd         out  1   one-cycle EAROM read strobe
//  mem_addr       out  ADDR_W  EAROM read address
//  mem_q          in   8   EAROM read data, valid MEM_LAT cycles after mem_rd
//  upload_done    out  1   one-cycle pulse when ioctl_upload falls
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, ioctl_din=8'h00, ioctl_wait=0, mem_rd=0, mem_addr=0, upload_done=0.
//  States: IDLE, HOLD, ISSUE, LAT, CAPT.
//  IDLE: ioctl_rd & ioctl_upload & ioctl_addr<DEPTH -> latch addr; ioctl_wait<=1; ->HOLD.
//        ioctl_rd & addr>=DEPTH (and not checksum slot) -> ioctl_din<=8'hFF next edge, wait stays 0, stay IDLE.
//        ioctl_rd while ioctl_upload=0 -> ignored.
//  HOLD: cpu_busy=1 -> stay (wait held); cpu_busy=0 -> ISSUE.
//  ISSUE: mem_rd=1, mem_addr=latched addr[ADDR_W-1:0] for exactly one cycle -> LAT.
//  LAT: count MEM_LAT-1 further cycles (0 when MEM_LAT=1) -> CAPT; cpu_busy here has no effect (read owns port).
//  CAPT: ioctl_din<=mem_q, ioctl_wait<=0 on same edge -> IDLE.
//  Latency rd->data (cpu_busy=0): MEM_LAT+3 edges; wait high MEM_LAT+2 cycles.
//  ioctl_rd while ioctl_wait=1: protocol violation, ignored.
//  ioctl_upload falling in any state: abort -> IDLE, wait<=0, mem_rd<=0; upload_done=1 for one cycle.
//  Rising ioctl_upload clears all session state (incl. checksum). ioctl_addr upper bits compared full-width.
// CONFIGURATION
//  EAROM_UPLOAD_CSUM_EN defined: address DEPTH returns checksum byte C with (sum of bytes 0..DEPTH-1 + C) mod 256 == 0,
//   accumulated over bytes delivered in CAPT in strictly ascending sequence from 0; any out-of-order/repeated read
//   sets csum_bad and slot DEPTH returns 8'h00 wait-free... slot DEPTH answered in one cycle, wait stays 0.
//   Addresses > DEPTH return 8'hFF.
//  Not defined: no accumulator; address DEPTH returns 8'hFF like any out-of-range address.
// STRUCTURE
//  Package earom_pkg: state enum (IDLE,HOLD,ISSUE,LAT,CAPT), EAROM_DEPTH=64, EAROM_AW=6, FILL_BYTE=8'hFF.
//  Single flat module; no sub-module (latency counter and checksum adder inline).
// TESTING
//  T1 mem[5]=8'hA7, upload=1, rd addr 5, MEM_LAT=1 -> mem_rd one cycle addr 5; ioctl_din=8'hA7 at edge 4; wait high 3 cycles.
//  T2 cpu_busy=1 for 10 cycles after rd addr 0 -> no mem_rd, wait high throughout; data 9+ cycles later, correct byte.
//  T3 rd addr 64 and 25'h1FFFFFF (CSUM off) -> ioctl_din=8'hFF next edge, ioctl_wait never asserted, no mem_rd.
//  T4 CSUM on, mem=i+1 for i=0..63, read 0..64 sequential -> byte 64 = 8'hE0 (sum 2080=8'h20); re-read 3 first -> 8'h00.
//  T5 drop ioctl_upload during LAT -> state IDLE, wait=0 next edge, upload_done single pulse, no stray ioctl_din update.
//  T6 assert reset mid-HOLD asynchronously -> all outputs to reset values before next clk_sys edge.

Source files
------------

// File: rtl/earom_upload_pkg.sv
// Shared types and constants for the EAROM upload path.
// Package name is earom_pkg; imported by the upload block and its bench.
package earom_pkg;

  localparam int         EAROM_DEPTH = 64;
  localparam int         EAROM_AW    = 6;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    ISSUE,
    LAT,
    CAPT
  } state_e;

endpackage

// File: rtl/earom_upload_if.sv
// HPS ioctl upload bus: master is hps_io, slave is the EAROM upload block.
interface earom_upload_if;

  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        upload_done;

  modport master (
    output ioctl_upload,
    output ioctl_rd,
    output ioctl_addr,
    input  ioctl_din,
    input  ioctl_wait,
    input  upload_done
  );

  modport slave (
    input  ioctl_upload,
    input  ioctl_rd,
    input  ioctl_addr,
    output ioctl_din,
    output ioctl_wait,
    output upload_done
  );

endinterface

// File: rtl/earom_upload.sv
// Streams the EAROM image back to the HPS one byte per ioctl_rd, yielding to CPU accesses.
// Optional checksum byte at address DEPTH when EAROM_UPLOAD_CSUM_EN is defined.
module earom_upload
  import earom_pkg::*;
#(
  parameter int ADDR_W  = EAROM_AW,
  parameter int DEPTH   = EAROM_DEPTH,
  parameter int MEM_LAT = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  earom_upload_if.slave     ioctl,
  input  logic              cpu_busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_q
);

  localparam logic [24:0] DEPTH_A  = 25'(DEPTH);
  localparam logic [1:0]  LAT_LOAD = 2'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic [1:0]        lat_q, lat_d;
  logic              upload_q;
  logic              done_q;

  logic accept_st;
  logic req;
  logic in_range;
  logic capture;
  logic upload_rise;

`ifdef EAROM_UPLOAD_CSUM_EN
  logic [7:0]      sum_q, sum_d;
  logic [ADDR_W:0] next_q, next_d;
  logic            bad_q, bad_d;
  logic            csum_slot;
  assign csum_slot = (ioctl.ioctl_addr == DEPTH_A);
`endif

  // CAPT presents the byte with wait already low, so it takes a new request just like IDLE.
  assign accept_st   = (state_q == IDLE) || (state_q == CAPT);
  assign req         = accept_st && ioctl.ioctl_rd && ioctl.ioctl_upload;
  assign in_range    = (ioctl.ioctl_addr < DEPTH_A);
  assign capture     = (state_q == LAT) && (lat_q == 2'd0) && ioctl.ioctl_upload;
  assign upload_rise = ioctl.ioctl_upload && !upload_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ioctl.ioctl_upload) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, CAPT: state_d = (req && in_range) ? HOLD : IDLE;
        HOLD:       state_d = cpu_busy ? HOLD : ISSUE;
        ISSUE:      state_d = LAT;
        LAT:        state_d = (lat_q == 2'd0) ? CAPT : LAT;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd = (state_q == ISSUE);
    addr_d = addr_q;
    din_d  = din_q;
    wait_d = wait_q;
    lat_d  = lat_q;

    if (req) begin
      if (in_range) begin
        addr_d = ioctl.ioctl_addr[ADDR_W-1:0];
        wait_d = 1'b1;
      end
`ifdef EAROM_UPLOAD_CSUM_EN
      else if (csum_slot) begin
        din_d = bad_q ? 8'h00 : (8'h00 - sum_q);
      end
`endif
      else begin
        din_d = FILL_BYTE;
      end
    end

    if (state_q == ISSUE) begin
      lat_d = LAT_LOAD;
    end else if ((state_q == LAT) && (lat_q != 2'd0)) begin
      lat_d = lat_q - 2'd1;
    end

    if (capture) begin
      din_d  = mem_q;
      wait_d = 1'b0;
    end

    if (!ioctl.ioctl_upload) begin
      wait_d = 1'b0;
    end

`ifdef EAROM_UPLOAD_CSUM_EN
    sum_d  = sum_q;
    next_d = next_q;
    bad_d  = bad_q;
    // Only a strictly ascending walk from address 0 yields a trustworthy checksum.
    if (upload_rise) begin
      sum_d  = 8'h00;
      next_d = '0;
      bad_d  = 1'b0;
    end else if (capture) begin
      if ({1'b0, addr_q} == next_q) begin
        sum_d  = sum_q + mem_q;
        next_d = next_q + {{ADDR_W{1'b0}}, 1'b1};
      end else begin
        bad_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      din_q    <= 8'h00;
      wait_q   <= 1'b0;
      lat_q    <= 2'd0;
      upload_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef EAROM_UPLOAD_CSUM_EN
      sum_q    <= 8'h00;
      next_q   <= '0;
      bad_q    <= 1'b0;
`endif
    end else begin
      addr_q   <= addr_d;
      din_q    <= din_d;
      wait_q   <= wait_d;
      lat_q    <= lat_d;
      upload_q <= ioctl.ioctl_upload;
      done_q   <= upload_q && !ioctl.ioctl_upload;
`ifdef EAROM_UPLOAD_CSUM_EN
      sum_q    <= sum_d;
      next_q   <= next_d;
      bad_q    <= bad_d;
`endif
    end
  end

  assign mem_addr          = addr_q;
  assign ioctl.ioctl_din   = din_q;
  assign ioctl.ioctl_wait  = wait_q;
  assign ioctl.upload_done = done_q;

endmodule

// File: tb/tb_earom_upload.sv
// Directed bench for earom_upload: table of single reads plus hand-written abort/reset/busy sequences.
// Checksum sequence only runs when EAROM_UPLOAD_CSUM_EN is defined.
module tb_earom_upload;
  import earom_pkg::*;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       cpu_busy;
  logic       mem_rd;
  logic [5:0] mem_addr;
  logic [7:0] mem_q;
  logic [7:0] mem [64];
  int         rdCount = 0;
  int         total   = 0;
  int         passed  = 0;

  earom_upload_if ioctl ();

  earom_upload #(.ADDR_W(6), .DEPTH(64), .MEM_LAT(1)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ioctl    (ioctl),
    .cpu_busy (cpu_busy),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_q    (mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  // One-cycle-latency EAROM model; also counts read strobes seen at each edge.
  always @(posedge clk_sys) begin
    if (mem_rd) begin
      mem_q   <= mem[mem_addr];
      rdCount <= rdCount + 1;
    end
  end

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  expDin;
    int          expWait;
    int          expRds;
    int          expEdges;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyStimulus(input logic [24:0] addr, input int busyCycles,
                               output logic [7:0] din, output int waitCycles,
                               output int edges, output int rds);
    int startRd;
    startRd = rdCount;
    ioctl.ioctl_addr = addr;
    ioctl.ioctl_rd   = 1'b1;
    cpu_busy         = (busyCycles > 0);
    step();
    ioctl.ioctl_rd = 1'b0;
    edges      = 1;
    waitCycles = 0;
    while (ioctl.ioctl_wait && edges < 40) begin
      waitCycles++;
      if (edges >= busyCycles) cpu_busy = 1'b0;
      step();
      edges++;
    end
    cpu_busy = 1'b0;
    din = ioctl.ioctl_din;
    rds = rdCount - startRd;
  endtask

  initial begin
    logic [7:0] din;
    logic [7:0] held;
    int         wc, ed, rds;

    ioctl.ioctl_upload = 1'b0;
    ioctl.ioctl_rd     = 1'b0;
    ioctl.ioctl_addr   = '0;
    cpu_busy           = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 1);
    mem[5] = 8'hA7;

    vecs.push_back('{25'd5,        8'hA7, 3, 1, 4});
    vecs.push_back('{25'd64,       8'hFF, 0, 0, 1});
    vecs.push_back('{25'd0,        8'h01, 3, 1, 4});
    vecs.push_back('{25'h1FFFFFF,  8'hFF, 0, 0, 1});
    vecs.push_back('{25'd63,       8'h40, 3, 1, 4});
    vecs.push_back('{25'd65,       8'hFF, 0, 0, 1});
    vecs.push_back('{25'd31,       8'h20, 3, 1, 4});
    vecs.push_back('{25'h0100005,  8'hFF, 0, 0, 1});

    step();
    step();
    checkOutput("reset din",  ioctl.ioctl_din,   0);
    checkOutput("reset wait", ioctl.ioctl_wait,  0);
    checkOutput("reset rd",   mem_rd,            0);
    checkOutput("reset addr", mem_addr,          0);
    checkOutput("reset done", ioctl.upload_done, 0);
    reset = 1'b0;
    ioctl.ioctl_upload = 1'b1;
    step();

    foreach (vecs[k]) begin
`ifdef EAROM_UPLOAD_CSUM_EN
      if (vecs[k].addr == 25'd64) continue;
`endif
      applyStimulus(vecs[k].addr, 0, din, wc, ed, rds);
      checkOutput($sformatf("vec%0d din", k),   din, vecs[k].expDin);
      checkOutput($sformatf("vec%0d wait", k),  wc,  vecs[k].expWait);
      checkOutput($sformatf("vec%0d rds", k),   rds, vecs[k].expRds);
      checkOutput($sformatf("vec%0d edges", k), ed,  vecs[k].expEdges);
      step();
    end

    // CPU holds the EAROM for 10 cycles after the request.
    applyStimulus(25'd0, 10, din, wc, ed, rds);
    checkOutput("busy din",   din, 8'h01);
    checkOutput("busy wait",  wc,  12);
    checkOutput("busy edges", ed,  13);
    checkOutput("busy rds",   rds, 1);
    step();

    // Requests outside an upload session are ignored; falling upload pulses upload_done once.
    ioctl.ioctl_upload = 1'b0;
    step();
    checkOutput("done pulse", ioctl.upload_done, 1);
    applyStimulus(25'd5, 0, din, wc, ed, rds);
    checkOutput("noupl din",  din, 8'h01);
    checkOutput("noupl wait", wc,  0);
    checkOutput("noupl rds",  rds, 0);
    checkOutput("done once",  ioctl.upload_done, 0);
    ioctl.ioctl_upload = 1'b1;
    step();

    // Abort with the read in flight.
    held = ioctl.ioctl_din;
    ioctl.ioctl_addr = 25'd7;
    ioctl.ioctl_rd   = 1'b1;
    step();
    ioctl.ioctl_rd = 1'b0;
    step();
    step();
    checkOutput("abort pre wait", ioctl.ioctl_wait, 1);
    ioctl.ioctl_upload = 1'b0;
    step();
    checkOutput("abort wait", ioctl.ioctl_wait,  0);
    checkOutput("abort done", ioctl.upload_done, 1);
    checkOutput("abort din",  ioctl.ioctl_din,   held);
    step();
    checkOutput("abort done low", ioctl.upload_done, 0);
    checkOutput("abort din hold", ioctl.ioctl_din,   held);
    ioctl.ioctl_upload = 1'b1;
    step();

    // Asynchronous reset while parked in HOLD.
    applyStimulus(25'd9, 0, din, wc, ed, rds);
    checkOutput("pre-reset din", din, 8'h0A);
    cpu_busy = 1'b1;
    ioctl.ioctl_addr = 25'd9;
    ioctl.ioctl_rd   = 1'b1;
    step();
    ioctl.ioctl_rd = 1'b0;
    checkOutput("hold wait",  ioctl.ioctl_wait, 1);
    checkOutput("hold addr",  mem_addr,         9);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async din",  ioctl.ioctl_din,   0);
    checkOutput("async wait", ioctl.ioctl_wait,  0);
    checkOutput("async rd",   mem_rd,            0);
    checkOutput("async addr", mem_addr,          0);
    checkOutput("async done", ioctl.upload_done, 0);
    @(negedge clk_sys);
    reset    = 1'b0;
    cpu_busy = 1'b0;
    step();

`ifdef EAROM_UPLOAD_CSUM_EN
    mem[5] = 8'h06;
    ioctl.ioctl_upload = 1'b0;
    step();
    ioctl.ioctl_upload = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(25'(i), 0, din, wc, ed, rds);
      checkOutput($sformatf("seq%0d din", i), din, i + 1);
    end
    applyStimulus(25'd64, 0, din, wc, ed, rds);
    checkOutput("csum din",   din, 8'hE0);
    checkOutput("csum wait",  wc,  0);
    checkOutput("csum edges", ed,  1);
    applyStimulus(25'd3, 0, din, wc, ed, rds);
    checkOutput("reread din", din, 8'h04);
    applyStimulus(25'd64, 0, din, wc, ed, rds);
    checkOutput("csum bad",   din, 8'h00);
    applyStimulus(25'd65, 0, din, wc, ed, rds);
    checkOutput("csum beyond", din, 8'hFF);
`endif

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
